// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache. Hits return in the same cycle;
// misses stall the CPU and fetch one whole block over a read/busywait handshake.
module instr_cache #(
    parameter int unsigned NUM_SETS  = 8,
    parameter int unsigned WORDS_PER = 4,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic [31:0]                         PC,
    output logic [31:0]                         INSTRUCTION,
    output logic                                BUSYWAIT,
    output logic                                mem_read,
    output logic [ADDR_W-$clog2(WORDS_PER)-3:0] mem_address,
    input  logic [32*WORDS_PER-1:0]             mem_readdata,
    input  logic                                mem_busywait
);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned OFF_W = $clog2(WORDS_PER);
    localparam int unsigned BA_W  = ADDR_W - OFF_W - 2;
    localparam int unsigned TAG_W = BA_W - IDX_W;
    localparam int unsigned BLK_W = 32 * WORDS_PER;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t              state_q, state_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [BA_W-1:0]     miss_addr_q, miss_addr_d;
    logic [BLK_W-1:0]    fill_q, fill_d;
    logic                mem_read_q, mem_read_d;
    logic                line_we;

    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [BLK_W-1:0]    data_arr [NUM_SETS];

    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    pc_idx;
    logic [OFF_W-1:0]    pc_off;
    logic [IDX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic                hit;
    logic                unused_pc;

    assign pc_tag    = PC[ADDR_W-1 -: TAG_W];
    assign pc_idx    = PC[OFF_W+2 +: IDX_W];
    assign pc_off    = PC[2 +: OFF_W];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};
    assign miss_idx  = miss_addr_q[IDX_W-1:0];
    assign miss_tag  = miss_addr_q[BA_W-1:IDX_W];

    assign hit         = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign INSTRUCTION = data_arr[pc_idx][{pc_off, 5'd0} +: 32];
    assign BUSYWAIT    = !RESET && ((state_q != IDLE) || !hit);
    assign mem_read    = mem_read_q;
    assign mem_address = miss_addr_q;

    // Reset is folded into the next-state logic so every flop below stays a plain register.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        fill_d      = fill_q;
        mem_read_d  = 1'b0;
        line_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d     = MEM_READ;
                    miss_addr_d = PC[ADDR_W-1:OFF_W+2];
                    mem_read_d  = 1'b1;
                end
            end
            MEM_READ: begin
                mem_read_d = 1'b1;
                if (!mem_busywait) begin
                    state_d    = UPDATE;
                    fill_d     = mem_readdata;
                    mem_read_d = 1'b0;
                end
            end
            UPDATE: begin
                state_d           = IDLE;
                valid_d[miss_idx] = 1'b1;
                line_we           = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (RESET) begin
            state_d     = IDLE;
            valid_d     = '0;
            miss_addr_d = '0;
            mem_read_d  = 1'b0;
            line_we     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q     <= state_d;
        valid_q     <= valid_d;
        miss_addr_q <= miss_addr_d;
        fill_q      <= fill_d;
        mem_read_q  <= mem_read_d;
    end

    // Tag and data storage is never cleared; the valid bits alone gate hits.
    always_ff @(posedge CLK) begin
        if (line_we) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= fill_q;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios followed by random
// fetches, all checked against a line-level cache model and a block memory array.
module tb_instr_cache;
    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  PC = '0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait = 1'b0;

    logic [127:0] mem_blk [64];
    bit           m_valid [8];
    logic [2:0]   m_tag   [8];
    logic [127:0] m_data  [8];

    int n_cmp = 0;
    int n_bad = 0;
    int busy_left = 0;

    instr_cache #(.NUM_SETS(8), .WORDS_PER(4), .ADDR_W(10)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT), .mem_read(mem_read), .mem_address(mem_address),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    assign mem_readdata = mem_blk[mem_address];

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory: busy for busy_left MEM_READ cycles, then data valid.
    task automatic drive_mem();
        mem_busywait = (busy_left > 0);
        if (mem_read && busy_left > 0) busy_left--;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RESET = 1'b1;
            busy_left = 0;
            drive_mem();
            #1;
            check("rst_busywait", BUSYWAIT, 0);
            if (i > 0) begin
                check("rst_mem_read", mem_read, 0);
                check("rst_mem_addr", mem_address, 0);
            end
        end
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
    endtask

    task automatic fetch(input logic [31:0] pc, input int nbusy,
                         input logic [31:0] alt, input bit use_alt);
        logic [2:0] idx;
        logic [5:0] blk;
        logic [1:0] off;
        bit         exp_miss, done;
        int         stall, rd, bad_addr;
        idx = pc[6:4];
        blk = pc[9:4];
        off = pc[3:2];
        exp_miss = !(m_valid[idx] && m_tag[idx] == pc[9:7]);
        @(negedge CLK);
        RESET = 1'b0;
        PC = pc;
        busy_left = nbusy;
        drive_mem();
        #1;
        check("miss_detect", BUSYWAIT, exp_miss);
        if (exp_miss) begin
            stall = 0; rd = 0; bad_addr = 0; done = 0;
            for (int c = 0; c < 64 && !done; c++) begin
                @(negedge CLK);
                drive_mem();
                if (use_alt) PC = mem_read ? alt : pc;
                #1;
                if (!BUSYWAIT) done = 1;
                else begin
                    stall++;
                    if (mem_read) begin
                        rd++;
                        if (mem_address !== blk) bad_addr++;
                    end
                end
            end
            check("fill_done", done, 1);
            check("read_cycles", rd, nbusy + 1);
            check("stall_cycles", stall, nbusy + 2);
            check("mem_address", bad_addr, 0);
            m_valid[idx] = 1;
            m_tag[idx]   = pc[9:7];
            m_data[idx]  = mem_blk[blk];
        end else begin
            check("hit_no_read", mem_read, 0);
        end
        check("instruction", INSTRUCTION, m_data[idx][{off, 5'd0} +: 32]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd, pc, alt;
        int          r;
        for (int a = 0; a < 64; a++) mem_blk[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
        mem_blk[0] = {32'h4, 32'h3, 32'h2, 32'h1};

        // Cold miss with a 5-busy-cycle memory, then same-block hits.
        do_reset(2);
        fetch(32'h000, 5, 0, 0);
        check("cold_instr", INSTRUCTION, 32'h1);
        fetch(32'h004, 0, 0, 0);
        check("hit_w1", INSTRUCTION, 32'h2);
        fetch(32'h008, 0, 0, 0);
        check("hit_w2", INSTRUCTION, 32'h3);
        fetch(32'h00C, 0, 0, 0);
        check("hit_w3", INSTRUCTION, 32'h4);

        // Conflict on index 0, then back to the original block.
        fetch(32'h080, 2, 0, 0);
        fetch(32'h000, 1, 0, 0);
        check("refill_instr", INSTRUCTION, 32'h1);

        // Zero-wait memory at the top of the address space, then the alias of 0.
        fetch(32'h3FC, 0, 0, 0);
        fetch(32'h400, 0, 0, 0);

        // Reset during MEM_READ aborts the fill.
        @(negedge CLK);
        RESET = 1'b0;
        PC = 32'h010;
        busy_left = 3;
        drive_mem();
        #1;
        check("rmf_miss", BUSYWAIT, 1);
        @(negedge CLK);
        drive_mem();
        #1;
        check("rmf_in_read", mem_read, 1);
        check("rmf_addr", mem_address, 6'h01);
        RESET = 1'b1;
        #1;
        check("rmf_bw_forced", BUSYWAIT, 0);
        @(negedge CLK);
        busy_left = 0;
        mem_busywait = 1'b0;
        #1;
        check("rmf_read_drop", mem_read, 0);
        check("rmf_addr_clr", mem_address, 0);
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        fetch(32'h010, 2, 0, 0);

        // PC perturbation during MEM_READ.
        fetch(32'h020, 3, 32'h040, 1);
        fetch(32'h040, 1, 0, 0);

        // Random fetches over a small pool of blocks so hits and conflicts both occur.
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset($urandom_range(1, 2));
            end else if (r < 8) begin
                mem_blk[$urandom_range(0, 63)] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                rnd = $urandom();
                pc = {rnd[31:10], 3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), rnd[3:0]};
                alt = $urandom();
                fetch(pc, $urandom_range(0, 4), alt, (r < 15));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
